// File: rtl/atconv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : atconv_pkg
// Brief    : Shared sizes, layer-select codes and host FSM states for the
//            atrous-convolution memory host.
// Revision : 1.0
// ============================================================================
package atconv_pkg;

    localparam int DW        = 13;
    localparam int AW        = 12;
    localparam int IMG_WORDS = 4096;
    localparam int L0_WORDS  = 4096;
    localparam int L1_WORDS  = 1024;
    localparam int IMG_DIM   = 64;
    localparam int L1_DIM    = 32;
    localparam int L1_AW     = $clog2(L1_WORDS);

    localparam logic LAYER0 = 1'b0;
    localparam logic LAYER1 = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_KICK      = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_RUN       = 3'd4,
        ST_DUMP      = 3'd5,
        ST_DONE      = 3'd6
    } host_state_e;

endpackage
`default_nettype wire

// File: rtl/atconv_mem_host_if.sv
`default_nettype none
// ============================================================================
// Module   : atconv_mem_host_if
// Brief    : Host streams plus engine-side memory bus of atconv_mem_host.
// Revision : 1.0
// ============================================================================
interface atconv_mem_host_if;
    import atconv_pkg::*;

    logic          start;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          out_ready;
    logic          done;
    logic          err;
    logic          ready;
    logic          busy;
    logic [AW-1:0] iaddr;
    logic [DW-1:0] idata;
    logic          cwr;
    logic [AW-1:0] caddr_wr;
    logic [DW-1:0] cdata_wr;
    logic          crd;
    logic [AW-1:0] caddr_rd;
    logic [DW-1:0] cdata_rd;
    logic          csel;

    modport slave (
        input  start, in_valid, in_data, out_ready, busy, iaddr,
               cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel,
        output in_ready, out_valid, out_data, out_last, done, err, ready,
               idata, cdata_rd
    );

    modport master (
        output start, in_valid, in_data, out_ready, busy, iaddr,
               cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel,
        input  in_ready, out_valid, out_data, out_last, done, err, ready,
               idata, cdata_rd
    );

endinterface
`default_nettype wire

// File: rtl/atconv_sram.sv
`default_nettype none
// ============================================================================
// Module   : atconv_sram
// Brief    : Synchronous-write memory with N_RD asynchronous read ports.
// Revision : 1.0
// ============================================================================
module atconv_sram #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 13,
    parameter int N_RD  = 1,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  wire logic                          clk,
    input  wire logic                          i_we,
    input  wire logic [ADDR_W-1:0]             i_waddr,
    input  wire logic [WIDTH-1:0]              i_wdata,
    input  wire logic [N_RD-1:0][ADDR_W-1:0]   i_raddr,
    output logic      [N_RD-1:0][WIDTH-1:0]    o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Contents are deliberately left unreset; only the pointers around it are.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    for (genvar g = 0; g < N_RD; g++) begin : g_rd
        assign o_rdata[g] = r_mem[i_raddr[g]];
    end

endmodule
`default_nettype wire

// File: rtl/atconv_mem_host.sv
`default_nettype none
// ============================================================================
// Module   : atconv_mem_host
// Brief    : Image/layer buffers for the atconv engine and the run sequencer.
// Revision : 1.0
// ============================================================================
module atconv_mem_host
    import atconv_pkg::*;
#(
    parameter int BUSY_TIMEOUT = 16
) (
    input  wire logic         clk,
    input  wire logic         reset,
    atconv_mem_host_if.slave  bus
);

    localparam int TO_W = $clog2(BUSY_TIMEOUT + 1);

    host_state_e       r_state;
    host_state_e       w_state_nxt;
    logic [AW-1:0]     r_wr_ptr;
    logic [L1_AW-1:0]  r_rd_ptr;
    logic [TO_W-1:0]   r_to_cnt;
    logic              r_err;

    logic              w_in_ready;
    logic              w_ready;
    logic              w_out_valid;
    logic              w_done;
    logic              w_img_we;
    logic              w_out_hs;
    logic              w_to_expire;
    logic              w_to_err;
    logic              w_layer_wr_ok;
    logic              w_l1_oob;
    logic              w_l0_we;
    logic              w_l1_we;
    logic              w_wr_err;

    logic [0:0][AW-1:0]    w_img_raddr;
    logic [0:0][DW-1:0]    w_img_rdata;
    logic [0:0][AW-1:0]    w_l0_raddr;
    logic [0:0][DW-1:0]    w_l0_rdata;
    logic [1:0][L1_AW-1:0] w_l1_raddr;
    logic [1:0][DW-1:0]    w_l1_rdata;

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign w_to_expire = (r_to_cnt == TO_W'(BUSY_TIMEOUT - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_ready     = 1'b0;
        w_out_valid = 1'b0;
        w_done      = 1'b0;
        w_to_err    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) w_state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                w_in_ready = 1'b1;
                if (bus.in_valid && (r_wr_ptr == AW'(IMG_WORDS - 1))) begin
                    w_state_nxt = ST_KICK;
                end
            end
            ST_KICK: begin
                w_ready     = 1'b1;
                w_state_nxt = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (bus.busy) begin
                    w_state_nxt = ST_RUN;
                end else if (w_to_expire) begin
                    w_to_err    = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_RUN: begin
                if (!bus.busy) w_state_nxt = ST_DUMP;
            end
            ST_DUMP: begin
                w_out_valid = 1'b1;
                if (bus.out_ready && (r_rd_ptr == L1_AW'(L1_WORDS - 1))) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_img_we = bus.in_valid && w_in_ready;
    assign w_out_hs = w_out_valid && bus.out_ready;

    // ------------------------------------------------------------------
    // Layer write qualification
    // ------------------------------------------------------------------
    assign w_layer_wr_ok = (r_state == ST_WAIT_BUSY) || (r_state == ST_RUN);
    assign w_l1_oob      = (bus.caddr_wr >= AW'(L1_WORDS));
    assign w_l0_we       = bus.cwr && w_layer_wr_ok && (bus.csel == LAYER0);
    assign w_l1_we       = bus.cwr && w_layer_wr_ok && (bus.csel == LAYER1) && !w_l1_oob;
    assign w_wr_err      = bus.cwr && (!w_layer_wr_ok || ((bus.csel == LAYER1) && w_l1_oob));

    // Both pointers wrap to zero on their final transfer, which is the
    // clear-on-completion behaviour the next run relies on.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_to_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_img_we) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_out_hs) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (r_state == ST_WAIT_BUSY) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end else begin
                r_to_cnt <= '0;
            end
            if (w_wr_err || w_to_err) r_err <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Buffers
    // ------------------------------------------------------------------
    assign w_img_raddr[0] = bus.iaddr;
    assign w_l0_raddr[0]  = bus.caddr_rd;
    assign w_l1_raddr[0]  = L1_AW'(bus.caddr_rd);
    assign w_l1_raddr[1]  = r_rd_ptr;

    atconv_sram #(.DEPTH(IMG_WORDS), .WIDTH(DW), .N_RD(1)) u_img (
        .clk     (clk),
        .i_we    (w_img_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (bus.in_data),
        .i_raddr (w_img_raddr),
        .o_rdata (w_img_rdata)
    );

    atconv_sram #(.DEPTH(L0_WORDS), .WIDTH(DW), .N_RD(1)) u_l0 (
        .clk     (clk),
        .i_we    (w_l0_we),
        .i_waddr (bus.caddr_wr),
        .i_wdata (bus.cdata_wr),
        .i_raddr (w_l0_raddr),
        .o_rdata (w_l0_rdata)
    );

    atconv_sram #(.DEPTH(L1_WORDS), .WIDTH(DW), .N_RD(2)) u_l1 (
        .clk     (clk),
        .i_we    (w_l1_we),
        .i_waddr (L1_AW'(bus.caddr_wr)),
        .i_wdata (bus.cdata_wr),
        .i_raddr (w_l1_raddr),
        .o_rdata (w_l1_rdata)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.in_ready  = w_in_ready;
    assign bus.ready     = w_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = w_l1_rdata[1];
    assign bus.out_last  = w_out_valid && (r_rd_ptr == L1_AW'(L1_WORDS - 1));
    assign bus.done      = w_done;
    assign bus.err       = r_err;
    assign bus.idata     = w_img_rdata[0];
    assign bus.cdata_rd  = !bus.crd             ? '0 :
                           (bus.csel == LAYER1) ? w_l1_rdata[0] : w_l0_rdata[0];

endmodule
`default_nettype wire
